// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers.
// A grant lasts up to BURST_LEN beats and every burst is followed by one IDLE arbitration cycle.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DW-1:0]         req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wren,
  output logic [DW-1:0]              fifo_wr_data,
  output logic                       grant_valid,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       burst_done
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state_q, state_d;
  logic [GW-1:0]  grant_id_q, grant_id_d;
  logic [GW-1:0]  last_grant_q, last_grant_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

  logic [GW-1:0]  pick;
  logic           pick_found;
  logic           cur_valid;
  logic           xfer;
  logic           last_beat;

  // Rotating priority search starting just after the previous winner.
  always_comb begin
    int idx;
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant_q) + k) % NREQ;
      if (!pick_found && req_valid[idx]) begin
        pick       = GW'(idx);
        pick_found = 1'b1;
      end
    end
  end

  assign cur_valid = req_valid[grant_id_q];
  assign last_beat = (beat_cnt_q == CW'(BURST_LEN - 1));

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready    = '0;
    fifo_wren    = 1'b0;
    fifo_wr_data = '0;
    burst_done   = 1'b0;
    xfer         = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        req_ready[grant_id_q] = !fifo_full;
        fifo_wr_data          = req_data[int'(grant_id_q)*DW +: DW];
        xfer                  = cur_valid && !fifo_full;
        fifo_wren             = xfer;
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        // A dropped valid ends the burst even while the FIFO is full.
        if (!cur_valid || (xfer && last_beat)) begin
          burst_done   = 1'b1;
          state_d      = IDLE;
          last_grant_d = grant_id_q;
          beat_cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NREQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign grant_valid = (state_q == BURST);
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single requester, round-robin, backpressure,
// early release, reset mid-burst and a randomly drained FIFO model.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 fifo_full;
  logic                 fifo_wren;
  logic [DW-1:0]        fifo_wr_data;
  logic                 grant_valid;
  logic [1:0]           grant_id;
  logic                 burst_done;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  int         cnt  [NREQ];
  int         lim  [NREQ];
  logic [7:0] base [NREQ];
  int         exp_n[NREQ];
  bit         full_force = 1'b0;
  bit         sys_mode   = 1'b0;
  int         fcount     = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wren(fifo_wren),
    .fifo_wr_data(fifo_wr_data), .grant_valid(grant_valid),
    .grant_id(grant_id), .burst_done(burst_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = (cnt[i] < lim[i]);
      req_data[i*DW +: DW]   = base[i] + 8'(cnt[i]);
    end
    fifo_full = sys_mode ? (fcount >= 8) : full_force;
  endtask

  task automatic apply();
    drive();
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] b, input int l);
    base[i] = b;
    cnt[i]  = 0;
    lim[i]  = l;
  endtask

  // Producers advance on the handshake seen just before the edge; the FIFO model fills/drains.
  task automatic tick();
    logic [NREQ-1:0] hs;
    logic            wr;
    logic            rd;
    hs = req_valid & req_ready;
    wr = fifo_wren;
    rd = sys_mode && (fcount > 0) && ($urandom_range(0, 2) == 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (hs[i]) cnt[i]++;
    if (sys_mode) fcount = fcount + int'(wr) - int'(rd);
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    #1;
  endtask

  task automatic exp_cyc(input string tag, input bit gv, input int gid, input bit wren,
                         input logic [7:0] data, input bit done, input logic [3:0] rdy);
    chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(gv));
    if (gid >= 0) chk({tag, ".grant_id"}, 32'(grant_id), gid);
    chk({tag, ".fifo_wren"}, 32'(fifo_wren), 32'(wren));
    chk({tag, ".fifo_wr_data"}, 32'(fifo_wr_data), 32'(data));
    chk({tag, ".burst_done"}, 32'(burst_done), 32'(done));
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
  endtask

  initial begin
    int g;
    int sum;
    logic [7:0] d;
    logic [1:0] r;

    // Reset state with a requester already valid
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h00, 0);
    set_req(0, 8'hAA, 5);
    apply();
    exp_cyc("reset", 0, 0, 0, 8'h00, 0, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Single requester: AA..AD, IDLE gap, AE, then valid drop
    exp_cyc("t1_idle0", 0, -1, 0, 8'h00, 0, 4'b0000); tick();
    for (int k = 0; k < 4; k++) begin
      exp_cyc($sformatf("t1_beat%0d", k), 1, 0, 1, 8'hAA + 8'(k), k == 3, 4'b0001);
      tick();
    end
    exp_cyc("t1_idle1", 0, -1, 0, 8'h00, 0, 4'b0000); tick();
    exp_cyc("t1_beatAE", 1, 0, 1, 8'hAE, 0, 4'b0001); tick();
    exp_cyc("t1_drop", 1, 0, 0, 8'hAF, 1, 4'b0001); tick();
    exp_cyc("t1_idle2", 0, -1, 0, 8'h00, 0, 4'b0000);

    // Round-robin: all four valid, order 0,1,2,3,0 with 4 beats each
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i * 8'h40), 8);
    apply();
    for (int b = 0; b < 5; b++) begin
      g = b % 4;
      exp_cyc($sformatf("t2_idle%0d", b), 0, -1, 0, 8'h00, 0, 4'b0000); tick();
      for (int k = 0; k < 4; k++) begin
        exp_cyc($sformatf("t2_b%0d_k%0d", b, k), 1, g, 1,
                base[g] + 8'((b / 4) * 4 + k), k == 3, 4'(1 << g));
        tick();
      end
    end
    for (int i = 0; i < NREQ; i++) lim[i] = 0;
    apply();
    exp_cyc("t2_quiet", 0, -1, 0, 8'h00, 0, 4'b0000); tick();

    // Backpressure on requester 1 after its second beat
    set_req(1, 8'h50, 4);
    apply();
    exp_cyc("t3_idle", 0, -1, 0, 8'h00, 0, 4'b0000); tick();
    exp_cyc("t3_beat0", 1, 1, 1, 8'h50, 0, 4'b0010); tick();
    exp_cyc("t3_beat1", 1, 1, 1, 8'h51, 0, 4'b0010); tick();
    full_force = 1'b1;
    apply();
    for (int s = 0; s < 3; s++) begin
      exp_cyc($sformatf("t3_stall%0d", s), 1, 1, 0, 8'h52, 0, 4'b0000); tick();
    end
    full_force = 1'b0;
    apply();
    exp_cyc("t3_beat2", 1, 1, 1, 8'h52, 0, 4'b0010); tick();
    exp_cyc("t3_beat3", 1, 1, 1, 8'h53, 1, 4'b0010); tick();
    exp_cyc("t3_idle2", 0, -1, 0, 8'h00, 0, 4'b0000);

    // Early release of requester 2 while requester 3 waits
    set_req(2, 8'h60, 2);
    set_req(3, 8'h70, 4);
    apply();
    exp_cyc("t4_idle0", 0, -1, 0, 8'h00, 0, 4'b0000); tick();
    exp_cyc("t4_r2b0", 1, 2, 1, 8'h60, 0, 4'b0100); tick();
    exp_cyc("t4_r2b1", 1, 2, 1, 8'h61, 0, 4'b0100); tick();
    exp_cyc("t4_r2drop", 1, 2, 0, 8'h62, 1, 4'b0100); tick();
    lim[2] = 4;
    set_req(0, 8'h80, 1);
    apply();
    exp_cyc("t4_idle1", 0, -1, 0, 8'h00, 0, 4'b0000); tick();
    for (int k = 0; k < 4; k++) begin
      exp_cyc($sformatf("t4_r3b%0d", k), 1, 3, 1, 8'h70 + 8'(k), k == 3, 4'b1000); tick();
    end
    exp_cyc("t4_idle2", 0, -1, 0, 8'h00, 0, 4'b0000); tick();
    exp_cyc("t4_r0b0", 1, 0, 1, 8'h80, 0, 4'b0001); tick();
    exp_cyc("t4_r0drop", 1, 0, 0, 8'h81, 1, 4'b0001); tick();
    exp_cyc("t4_idle3", 0, -1, 0, 8'h00, 0, 4'b0000); tick();
    exp_cyc("t4_r2b2", 1, 2, 1, 8'h62, 0, 4'b0100); tick();
    exp_cyc("t4_r2b3", 1, 2, 1, 8'h63, 0, 4'b0100); tick();
    exp_cyc("t4_r2drop2", 1, 2, 0, 8'h64, 1, 4'b0100); tick();
    exp_cyc("t4_idle4", 0, -1, 0, 8'h00, 0, 4'b0000);

    // Reset in the middle of requester 0's third beat
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i * 8'h40), 8);
    apply();
    exp_cyc("t5_idle", 0, -1, 0, 8'h00, 0, 4'b0000); tick();
    exp_cyc("t5_b0", 1, 0, 1, 8'h00, 0, 4'b0001); tick();
    exp_cyc("t5_b1", 1, 0, 1, 8'h01, 0, 4'b0001); tick();
    exp_cyc("t5_b2pre", 1, 0, 1, 8'h02, 0, 4'b0001);
    rst = 1'b1;
    #1;
    exp_cyc("t5_inrst", 0, 0, 0, 8'h00, 0, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    #1;
    exp_cyc("t5_idle2", 0, -1, 0, 8'h00, 0, 4'b0000); tick();
    exp_cyc("t5_b2", 1, 0, 1, 8'h02, 0, 4'b0001); tick();

    // System: FIFO model of depth 8 drained at random, in-order per requester
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 8'(i * 8'h40), 60);
      exp_n[i] = 0;
    end
    sys_mode = 1'b1;
    fcount   = 0;
    apply();
    for (int c = 0; c < 200; c++) begin
      if (fifo_wren) begin
        d = fifo_wr_data;
        r = d[7:6];
        chk($sformatf("sys_full_c%0d", c), 32'(fifo_full), 32'd0);
        chk($sformatf("sys_gid_c%0d", c), 32'(grant_id), 32'(r));
        chk($sformatf("sys_order_r%0d", r), 32'(d[5:0]), 32'(exp_n[r]));
        exp_n[r]++;
      end
      tick();
    end
    sum = 0;
    for (int i = 0; i < NREQ; i++) sum += exp_n[i];
    chk("sys_progress", 32'(sum >= 20), 32'd1);
    chk("sys_all_served", 32'((exp_n[0] > 0) && (exp_n[1] > 0) && (exp_n[2] > 0) && (exp_n[3] > 0)), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
